// File: rtl/glyph_raster_tx.sv
// glyph_raster_tx: renders a 4-bit character code as a row-major 8x8
// serial pixel stream, one pixel per valid/ready handshake.
//
// Ports:
//   CLK         clock, rising edge
//   CLR         synchronous active-low reset
//   CODE        character code to render
//   CODE_VALID  CODE is valid
//   CODE_READY  block can accept a code (IDLE only)
//   PIX         current pixel, 1 = ink (registered)
//   PIX_X/Y     column/row of current pixel (registered)
//   PIX_VALID   pixel outputs valid (EMIT only)
//   PIX_READY   downstream accepts the pixel
//   SOF/EOF     qualify pixel (0,0) / (7,7) (registered)
//   DONE        one-cycle pulse after the (7,7) pixel is accepted
module glyph_raster_tx #(
  parameter int GW = 8,
  parameter int GH = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] CODE,
  input  logic       CODE_VALID,
  output logic       CODE_READY,
  output logic       PIX,
  output logic [2:0] PIX_X,
  output logic [2:0] PIX_Y,
  output logic       PIX_VALID,
  input  logic       PIX_READY,
  output logic       SOF,
  output logic       EOF,
  output logic       DONE
);

  localparam logic [2:0] XMAX = 3'(GW - 1);
  localparam logic [2:0] YMAX = 3'(GH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  state_t state;
  state_t nstate;

  logic [3:0] code_q;
  logic [2:0] col;
  logic [2:0] lin;
  logic [7:0] word;
  logic       ink;
  logic       first_px;
  logic       last_px;
  logic       done_p;

  logic       code_ready;
  logic       pix_valid;
  logic       step;
  logic [2:0] ncol;
  logic [2:0] nlin;
  logic [7:0] cur_word;
  logic [7:0] next_word;

  // Glyph ROM. Row 0 sits in bits [63:56]; bit 7 of a row is x=0.
  // Codes 0x0-0xD are the shared hex-digit table used by the OCR side.
  function automatic logic [7:0] rom_row(
    input logic [3:0] c,
    input logic [2:0] r
  );
    logic [63:0] g;
    logic [5:0]  base;
    case (c)
      4'h0:    g = 64'h3C666E7666663C00;
      4'h1:    g = 64'h1838181818187E00;
      4'h2:    g = 64'h3C66060C30607E00;
      4'h3:    g = 64'h3C66061C06663C00;
      4'h4:    g = 64'h0C1C3C6C7E0C0C00;
      4'h5:    g = 64'h7E607C0606663C00;
      4'h6:    g = 64'h3C607C6666663C00;
      4'h7:    g = 64'h7E060C1830303000;
      4'h8:    g = 64'h3C66663C66663C00;
      4'h9:    g = 64'h3C66663E060C3800;
      4'hA:    g = 64'h183C66667E666600;
      4'hB:    g = 64'h7C66667C66667C00;
      4'hC:    g = 64'h3C66606060663C00;
      4'hD:    g = 64'h786C6666666C7800;
      4'hE:    g = {8{8'hFF}};
      default: g = 64'h0;
    endcase
    base = {~r, 3'b000};
    return g[base +: 8];
  endfunction

  assign step      = pix_valid && PIX_READY;
  assign ncol      = col + 3'd1;
  assign nlin      = lin + 3'd1;
  assign cur_word  = rom_row(code_q, lin);
  assign next_word = rom_row(code_q, nlin);

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate     = state;
    code_ready = 1'b0;
    pix_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        code_ready = 1'b1;
        if (CODE_VALID) nstate = LOAD;
      end
      LOAD: begin
        nstate = EMIT;
      end
      EMIT: begin
        pix_valid = 1'b1;
        if (PIX_READY && col == XMAX && lin == YMAX)
          nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // Pixel outputs are computed one step ahead so they come straight
  // from flops; a new row word is fetched on the x=7 step so rows
  // follow each other without a bubble.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      code_q   <= 4'h0;
      col      <= 3'd0;
      lin      <= 3'd0;
      word     <= 8'h00;
      ink      <= 1'b0;
      first_px <= 1'b0;
      last_px  <= 1'b0;
      done_p   <= 1'b0;
    end else begin
      done_p <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CODE_VALID) begin
            code_q   <= CODE;
            col      <= 3'd0;
            lin      <= 3'd0;
            ink      <= 1'b0;
            first_px <= 1'b0;
            last_px  <= 1'b0;
          end
        end
        LOAD: begin
          word     <= cur_word;
          ink      <= cur_word[7];
          first_px <= 1'b1;
          last_px  <= 1'b0;
        end
        EMIT: begin
          if (step) begin
            first_px <= 1'b0;
            if (col != XMAX) begin
              col     <= ncol;
              ink     <= word[~ncol];
              last_px <= (ncol == XMAX) && (lin == YMAX);
            end else if (lin != YMAX) begin
              col     <= 3'd0;
              lin     <= nlin;
              word    <= next_word;
              ink     <= next_word[7];
              last_px <= 1'b0;
            end else begin
              col     <= 3'd0;
              lin     <= 3'd0;
              ink     <= 1'b0;
              last_px <= 1'b0;
              done_p  <= 1'b1;
            end
          end
        end
        default: begin
          done_p <= 1'b0;
        end
      endcase
    end
  end

  assign CODE_READY = code_ready;
  assign PIX_VALID  = pix_valid;
  assign PIX        = ink;
  assign PIX_X      = col;
  assign PIX_Y      = lin;
  assign SOF        = first_px;
  assign EOF        = last_px;
  assign DONE       = done_p;

endmodule

// File: tb/tb_glyph_raster_tx.sv
// Testbench for glyph_raster_tx: table-driven glyph runs, random codes
// and back-pressure, plus hand sequences for busy input and resets.
module tb_glyph_raster_tx;

  logic       CLK;
  logic       CLR;
  logic [3:0] CODE;
  logic       CODE_VALID;
  logic       CODE_READY;
  logic       PIX;
  logic [2:0] PIX_X;
  logic [2:0] PIX_Y;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic       SOF;
  logic       EOF;
  logic       DONE;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] gtab [16];

  typedef struct {
    logic [3:0] code;
    int         mode;
    int         exp_pixels;
    int         exp_ink;
  } vec_t;

  vec_t vt [6];

  glyph_raster_tx #(.GW(8), .GH(8)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .CODE(CODE),
    .CODE_VALID(CODE_VALID),
    .CODE_READY(CODE_READY),
    .PIX(PIX),
    .PIX_X(PIX_X),
    .PIX_Y(PIX_Y),
    .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY),
    .SOF(SOF),
    .EOF(EOF),
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Pixel n of a glyph, row-major: bit (63 - n) of the 64-bit image.
  function automatic logic model_pix(input logic [3:0] c, input int n);
    logic [63:0] g;
    g = gtab[c];
    return g[63 - n];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] c, output int acc);
    int n;
    n = 0;
    while (!CODE_READY && n < 200) begin
      tick;
      n++;
    end
    chk("send_ready", CODE_READY, 1);
    CODE       = c;
    CODE_VALID = 1'b1;
    tick;
    acc        = cyc;
    CODE_VALID = 1'b0;
    CODE       = 4'($urandom);
  endtask

  // Starts just after the accepting edge. mode 0: always ready,
  // 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic collect(input logic [3:0] c, input int mode,
                         input int stop_at, output int got,
                         output int ink);
    int       iter;
    int       nvalid;
    logic     stall;
    logic [8:0] prev;
    iter   = 0;
    nvalid = 0;
    stall  = 1'b0;
    prev   = '0;
    got    = 0;
    ink    = 0;
    while (got < 64) begin
      if (iter > 2000) begin
        chk("collect_bound", got, 64);
        return;
      end
      chk("pix_valid", PIX_VALID, iter >= 1);
      chk("code_ready_busy", CODE_READY, 0);
      chk("done_busy", DONE, 0);
      if (PIX_VALID) begin
        nvalid++;
        chk("pix", PIX, model_pix(c, got));
        chk("pix_x", PIX_X, got % 8);
        chk("pix_y", PIX_Y, got / 8);
        chk("sof", SOF, got == 0);
        chk("eof", EOF, got == 63);
        if (stall) chk("stall_hold", {PIX, PIX_X, PIX_Y, SOF, EOF}, prev);
      end
      if (got == stop_at && PIX_VALID) return;
      case (mode)
        0:       PIX_READY = 1'b1;
        1:       PIX_READY = (iter % 3 == 1);
        default: PIX_READY = 1'($urandom_range(0, 1));
      endcase
      stall = PIX_VALID && !PIX_READY;
      prev  = {PIX, PIX_X, PIX_Y, SOF, EOF};
      if (PIX_VALID && PIX_READY) begin
        ink += int'(PIX);
        got++;
      end
      tick;
      iter++;
    end
    chk("done_pulse", DONE, 1);
    chk("ready_at_done", CODE_READY, 1);
    chk("valid_after", PIX_VALID, 0);
    if (mode == 0) chk("consecutive", nvalid, 64);
  endtask

  initial begin
    int a;
    int b;
    int got;
    int ink;
    logic [3:0] rc;

    gtab[0]  = 64'h3C666E7666663C00;
    gtab[1]  = 64'h1838181818187E00;
    gtab[2]  = 64'h3C66060C30607E00;
    gtab[3]  = 64'h3C66061C06663C00;
    gtab[4]  = 64'h0C1C3C6C7E0C0C00;
    gtab[5]  = 64'h7E607C0606663C00;
    gtab[6]  = 64'h3C607C6666663C00;
    gtab[7]  = 64'h7E060C1830303000;
    gtab[8]  = 64'h3C66663C66663C00;
    gtab[9]  = 64'h3C66663E060C3800;
    gtab[10] = 64'h183C66667E666600;
    gtab[11] = 64'h7C66667C66667C00;
    gtab[12] = 64'h3C66606060663C00;
    gtab[13] = 64'h786C6666666C7800;
    gtab[14] = 64'hFFFFFFFFFFFFFFFF;
    gtab[15] = 64'h0000000000000000;

    vt[0] = '{code: 4'hE, mode: 0, exp_pixels: 64, exp_ink: 64};
    vt[1] = '{code: 4'hF, mode: 1, exp_pixels: 64, exp_ink: 0};
    vt[2] = '{code: 4'h1, mode: 0, exp_pixels: 64,
              exp_ink: $countones(gtab[1])};
    vt[3] = '{code: 4'hA, mode: 2, exp_pixels: 64,
              exp_ink: $countones(gtab[10])};
    vt[4] = '{code: 4'h7, mode: 1, exp_pixels: 64,
              exp_ink: $countones(gtab[7])};
    vt[5] = '{code: 4'h0, mode: 2, exp_pixels: 64,
              exp_ink: $countones(gtab[0])};

    CLR        = 1'b0;
    CODE       = 4'($urandom);
    CODE_VALID = 1'($urandom);
    PIX_READY  = 1'($urandom);

    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_code_ready", CODE_READY, 1);
      chk("rst_outs", {PIX_VALID, PIX, PIX_X, PIX_Y, SOF, EOF, DONE}, 0);
      CODE       = 4'($urandom);
      CODE_VALID = 1'($urandom);
      PIX_READY  = 1'($urandom);
    end
    CLR        = 1'b1;
    CODE_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_ready", CODE_READY, 1);
      chk("idle_valid", PIX_VALID, 0);
    end

    for (int i = 0; i < 6; i++) begin
      send(vt[i].code, a);
      collect(vt[i].code, vt[i].mode, -1, got, ink);
      chk("vec_pixels", got, vt[i].exp_pixels);
      chk("vec_ink", ink, vt[i].exp_ink);
      tick;
      chk("done_one_cycle", DONE, 0);
    end

    for (int i = 0; i < 6; i++) begin
      rc = 4'($urandom);
      send(rc, a);
      collect(rc, 2, -1, got, ink);
      chk("rnd_ink", ink, $countones(gtab[rc]));
    end

    tick;
    CODE       = 4'hE;
    CODE_VALID = 1'b1;
    tick;
    a    = cyc;
    CODE = 4'hF;
    collect(4'hE, 0, -1, got, ink);
    chk("busy_ink", ink, 64);
    tick;
    b = cyc;
    chk("throughput", b - a, 66);
    CODE_VALID = 1'b0;
    collect(4'hF, 0, -1, got, ink);
    chk("after_busy_ink", ink, 0);

    tick;
    send(4'hE, a);
    collect(4'hE, 0, 35, got, ink);
    chk("abort_at", {PIX_Y, PIX_X}, {3'd4, 3'd3});
    CLR       = 1'b0;
    PIX_READY = 1'b1;
    tick;
    chk("abort_valid", PIX_VALID, 0);
    chk("abort_ready", CODE_READY, 1);
    chk("abort_done", DONE, 0);
    chk("abort_xy", {PIX_X, PIX_Y}, 0);
    CLR = 1'b1;
    tick;
    chk("abort_no_done", DONE, 0);
    send(4'hE, a);
    collect(4'hE, 0, -1, got, ink);
    chk("post_abort_ink", ink, 64);

    tick;
    send(4'h3, a);
    collect(4'h3, 2, 63, got, ink);
    CLR       = 1'b0;
    PIX_READY = 1'b1;
    tick;
    chk("last_rst_done", DONE, 0);
    CLR = 1'b1;
    tick;
    chk("last_rst_done2", DONE, 0);
    chk("last_rst_ready", CODE_READY, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
